// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and debounces raw A/B encoder pins, then tracks
// the Gray-code phase and emits one-cycle cw/ccw step pulses and an err pulse on double-bit jumps.
module quad_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic cw,
  output logic ccw,
  output logic err
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam int unsigned IW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(FILTER_LEN - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [1:0]             r_filt;
  logic [CW-1:0]          r_cnt [2];
  logic [IW-1:0]          r_init_cnt;
  logic [1:0]             r_prev;
  logic                   r_cw;
  logic                   r_ccw;
  logic                   r_err;
  logic [1:0]             w_syn;
  logic [1:0]             w_cw_next;

  assign w_syn     = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
  // Phase {a,b} clockwise order is 00 -> 10 -> 11 -> 01 -> 00.
  assign w_cw_next = {~r_prev[0], r_prev[1]};
  assign cw        = r_cw;
  assign ccw       = r_ccw;
  assign err       = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], a};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], b};
    end
  end

  // A channel's filtered value flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= '0;
      for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_state == S_INIT) begin
          r_filt[i] <= w_syn[i];
          r_cnt[i]  <= '0;
        end else if (w_syn[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_filt[i] <= w_syn[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_prev     <= '0;
      r_cw       <= 1'b0;
      r_ccw      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cw  <= 1'b0;
      r_ccw <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_init_cnt <= r_init_cnt + IW'(1);
          // Adopt the same synced phase the filters load on this edge so TRACK starts quiet.
          if (r_init_cnt == INIT_LAST) begin
            r_prev  <= w_syn;
            r_state <= S_TRACK;
          end
        end
        S_TRACK: begin
          r_prev <= r_filt;
          if ((r_prev ^ r_filt) == 2'b11) r_err <= 1'b1;
          else if (r_filt == w_cw_next)   r_cw  <= 1'b1;
          else if (r_filt != r_prev)      r_ccw <= 1'b1;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule
